fetch_unit: RTL and testbench

Instruction-fetch stage of the ATtiny20 core, directly driven by state_machine's `state`, `cycle_count` and `opcode_group` outputs.
- Owns the program counter and the instruction register.
- Reads one 16-bit word from program memory during STATE_IF and presents it to the decoder from STATE_ID onward.
- Applies absolute jumps, relative jumps and skip requests at the final STATE_WB cycle.

---
 rtl/fetch_unit_pkg.sv | 37 +++
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit_pc_next.sv | 43 ++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: core state codes, decoder
// group indices, PC update phases and the WB-last qualifier.
package fetch_unit_pkg;

  localparam int          PC_WIDTH_DEF   = 10;
  localparam logic [15:0] NOP_OPCODE_DEF = 16'h0000;

  localparam int STATE_COUNT = 3;

  typedef enum logic [STATE_COUNT-1:0] {
    STATE_RESET = 3'd0,
    STATE_IF    = 3'd1,
    STATE_ID    = 3'd2,
    STATE_EX    = 3'd3,
    STATE_MEM   = 3'd4,
    STATE_WB    = 3'd5
  } core_state_t;

  localparam int GROUP_COUNT        = 8;
  localparam int GROUP_TWO_CYCLE_WB = 5;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_STEP,
    PC_REDIRECT
  } pc_phase_t;

  // Two-cycle writeback groups only finish on their second WB cycle.
  function automatic logic is_wb_last(
    input core_state_t            state,
    input logic [GROUP_COUNT-1:0] group,
    input logic                   cycle_count
  );
    return (state == STATE_WB) && !(group[GROUP_TWO_CYCLE_WB] && !cycle_count);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Program memory read port: word address and read strobe from the fetch
// stage, asynchronous read data back from memory.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
);

  logic [PC_WIDTH-1:0] pm_addr;
  logic                pm_rd;
  logic [15:0]         pm_data;

  modport master (
    output pm_addr,
    output pm_rd,
    input  pm_data
  );

  modport slave (
    input  pm_addr,
    input  pm_rd,
    output pm_data
  );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next program counter: increment during IF, jump redirection at WB-last,
// otherwise hold. All arithmetic wraps modulo 2^PC_WIDTH.
module fetch_unit_pc_next
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  pc_phase_t           phase,
  input  logic                jump_abs,
  input  logic                jump_rel,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [11:0]         jump_offset,
  output logic [PC_WIDTH-1:0] pc_next
);

  localparam int EXT_W = (PC_WIDTH > 12) ? PC_WIDTH : 12;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_rel;

  assign pc_inc = pc + PC_WIDTH'(1);

  // Offset is sign-extended before the add; the sum is then truncated so a
  // backward jump below zero wraps to the top of program memory.
  assign pc_rel = PC_WIDTH'(EXT_W'(pc) + EXT_W'(signed'(jump_offset)));

  always_comb begin
    pc_next = pc;
    unique case (phase)
      PC_STEP: pc_next = pc_inc;
      PC_REDIRECT: begin
        if (jump_abs) begin
          pc_next = jump_target;
        end else if (jump_rel) begin
          pc_next = pc_rel;
        end
      end
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and instruction register, fetches one
// word per IF and applies jumps and skips at the last WB cycle.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          PC_WIDTH   = PC_WIDTH_DEF,
  parameter logic [15:0] NOP_OPCODE = NOP_OPCODE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  core_state_t            state,
  input  logic                   cycle_count,
  input  logic [GROUP_COUNT-1:0] opcode_group,
  fetch_unit_if.master           pm,
  input  logic                   jump_abs,
  input  logic                   jump_rel,
  input  logic [PC_WIDTH-1:0]    jump_target,
  input  logic [11:0]            jump_offset,
  input  logic                   skip_req,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [15:0]            instr,
  output logic                   instr_squashed
);

  logic                if_cycle;
  logic                wb_last;
  logic                skip_pending;
  pc_phase_t           phase;
  logic [PC_WIDTH-1:0] pc_nxt;

  assign if_cycle = (state == STATE_IF);
  assign wb_last  = is_wb_last(state, opcode_group, cycle_count);

  assign pm.pm_addr = pc;
  assign pm.pm_rd   = if_cycle;

  always_comb begin
    phase = PC_HOLD;
    if (if_cycle) begin
      phase = PC_STEP;
    end else if (wb_last) begin
      phase = PC_REDIRECT;
    end
  end

  fetch_unit_pc_next #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_next (
    .pc         (pc),
    .phase      (phase),
    .jump_abs   (jump_abs),
    .jump_rel   (jump_rel),
    .jump_target(jump_target),
    .jump_offset(jump_offset),
    .pc_next    (pc_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pc_nxt;
    end
  end

  // A pending skip turns the next fetched slot into a NOP; any jump at the
  // same WB-last wins and drops the skip request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr          <= NOP_OPCODE;
      instr_squashed <= 1'b0;
      skip_pending   <= 1'b0;
    end else if (if_cycle) begin
      if (skip_pending) begin
        instr          <= NOP_OPCODE;
        instr_squashed <= 1'b1;
        skip_pending   <= 1'b0;
      end else begin
        instr          <= pm.pm_data;
        instr_squashed <= 1'b0;
      end
    end else if (wb_last && skip_req && !jump_abs && !jump_rel) begin
      skip_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: straight-line fetch, absolute and relative
// jumps with wrap, skips, two-cycle WB qualification and async reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int PC_WIDTH = 10;

  logic                   clk = 1'b0;
  logic                   reset;
  core_state_t            state;
  logic                   cycle_count;
  logic [GROUP_COUNT-1:0] opcode_group;
  logic                   jump_abs;
  logic                   jump_rel;
  logic [PC_WIDTH-1:0]    jump_target;
  logic [11:0]            jump_offset;
  logic                   skip_req;
  logic [PC_WIDTH-1:0]    pc;
  logic [15:0]            instr;
  logic                   instr_squashed;

  logic [15:0] mem [0:1023];
  int assert_count = 0;
  int fail_count   = 0;

  fetch_unit_if #(.PC_WIDTH(PC_WIDTH)) pm_bus ();

  assign pm_bus.pm_data = mem[pm_bus.pm_addr];

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_WIDTH  (PC_WIDTH),
    .NOP_OPCODE(16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .state         (state),
    .cycle_count   (cycle_count),
    .opcode_group  (opcode_group),
    .pm            (pm_bus.master),
    .jump_abs      (jump_abs),
    .jump_rel      (jump_rel),
    .jump_target   (jump_target),
    .jump_offset   (jump_offset),
    .skip_req      (skip_req),
    .pc            (pc),
    .instr         (instr),
    .instr_squashed(instr_squashed)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock in the given state with the given request inputs.
  task automatic apply_stimulus(input core_state_t st, input logic cc,
                                input logic ja, input logic jr,
                                input logic [PC_WIDTH-1:0] tgt,
                                input logic [11:0] off, input logic sk);
    @(negedge clk);
    state       = st;
    cycle_count = cc;
    jump_abs    = ja;
    jump_rel    = jr;
    jump_target = tgt;
    jump_offset = off;
    skip_req    = sk;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input core_state_t st);
    apply_stimulus(st, 1'b0, 1'b0, 1'b0, '0, 12'h000, 1'b0);
  endtask

  // IF then ID, checking the read port during IF and the register results in ID.
  task automatic fetch(input string tag, input logic [PC_WIDTH-1:0] exp_addr,
                       input logic [15:0] exp_instr, input logic exp_sq,
                       input logic [PC_WIDTH-1:0] exp_pc);
    @(negedge clk);
    state       = STATE_IF;
    cycle_count = 1'b0;
    jump_abs    = 1'b0;
    jump_rel    = 1'b0;
    skip_req    = 1'b0;
    #1;
    check_output({tag, "_pm_rd_if"}, 32'(pm_bus.pm_rd), 32'd1);
    check_output({tag, "_pm_addr"}, 32'(pm_bus.pm_addr), 32'(exp_addr));
    @(posedge clk);
    #1;
    @(negedge clk);
    state = STATE_ID;
    #1;
    check_output({tag, "_pm_rd_id"}, 32'(pm_bus.pm_rd), 32'd0);
    check_output({tag, "_instr"}, 32'(instr), 32'(exp_instr));
    check_output({tag, "_squashed"}, 32'(instr_squashed), 32'(exp_sq));
    check_output({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
    mem[0]     = 16'h1111;
    mem[1]     = 16'h2222;
    mem[2]     = 16'h3333;
    mem[3]     = 16'h4444;
    mem[4]     = 16'h5555;
    mem[10'h09F] = 16'h9F9F;
    mem[10'h100] = 16'h6666;
    mem[10'h101] = 16'h7777;
    mem[10'h155] = 16'hABCD;
    mem[10'h3FE] = 16'h7E7E;
    mem[10'h3FF] = 16'h5A5A;

    reset        = 1'b1;
    state        = STATE_RESET;
    cycle_count  = 1'b0;
    opcode_group = '0;
    jump_abs     = 1'b0;
    jump_rel     = 1'b0;
    jump_target  = '0;
    jump_offset  = 12'h000;
    skip_req     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_pc", 32'(pc), 32'h0);
    check_output("reset_instr", 32'(instr), 32'h0);
    check_output("reset_squashed", 32'(instr_squashed), 32'h0);
    check_output("reset_pm_rd", 32'(pm_bus.pm_rd), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(STATE_RESET);

    // Straight-line code
    fetch("seq0", 10'h000, 16'h1111, 1'b0, 10'h001);
    step(STATE_EX);
    check_output("hold_ex_instr", 32'(instr), 32'h1111);
    step(STATE_MEM);
    step(STATE_WB);
    check_output("hold_wb_instr", 32'(instr), 32'h1111);
    fetch("seq1", 10'h001, 16'h2222, 1'b0, 10'h002);
    step(STATE_EX);
    step(STATE_MEM);
    step(STATE_WB);
    fetch("seq2", 10'h002, 16'h3333, 1'b0, 10'h003);
    step(STATE_EX);
    step(STATE_MEM);

    // Absolute jump
    apply_stimulus(STATE_WB, 1'b0, 1'b1, 1'b0, 10'h155, 12'h000, 1'b0);
    check_output("jabs_pc", 32'(pc), 32'h155);
    fetch("jabs_fetch", 10'h155, 16'hABCD, 1'b0, 10'h156);
    step(STATE_EX);
    step(STATE_MEM);
    apply_stimulus(STATE_WB, 1'b0, 1'b1, 1'b0, 10'h001, 12'h000, 1'b0);

    // Relative jump backwards past zero
    fetch("rel_setup", 10'h001, 16'h2222, 1'b0, 10'h002);
    step(STATE_EX);
    step(STATE_MEM);
    apply_stimulus(STATE_WB, 1'b0, 1'b0, 1'b1, 10'h000, 12'hFFD, 1'b0);
    check_output("jrel_neg_wrap", 32'(pc), 32'h3FF);
    fetch("if_wrap", 10'h3FF, 16'h5A5A, 1'b0, 10'h000);
    step(STATE_EX);
    step(STATE_MEM);

    // Jump together with skip: skip is discarded
    apply_stimulus(STATE_WB, 1'b0, 1'b1, 1'b0, 10'h3FE, 12'h000, 1'b1);
    check_output("jabs_skip_pc", 32'(pc), 32'h3FE);
    fetch("skip_dropped", 10'h3FE, 16'h7E7E, 1'b0, 10'h3FF);
    step(STATE_EX);
    step(STATE_MEM);
    apply_stimulus(STATE_WB, 1'b0, 1'b0, 1'b1, 10'h000, 12'h002, 1'b0);
    check_output("jrel_pos_wrap", 32'(pc), 32'h001);

    // Skip request
    fetch("pre_skip", 10'h001, 16'h2222, 1'b0, 10'h002);
    step(STATE_EX);
    step(STATE_MEM);
    apply_stimulus(STATE_WB, 1'b0, 1'b0, 1'b0, 10'h000, 12'h000, 1'b1);
    check_output("skip_pc_hold", 32'(pc), 32'h002);
    fetch("squash", 10'h002, 16'h0000, 1'b1, 10'h003);
    step(STATE_EX);
    check_output("squash_hold", 32'(instr_squashed), 32'h1);
    step(STATE_MEM);
    step(STATE_WB);
    fetch("post_skip", 10'h003, 16'h4444, 1'b0, 10'h004);
    step(STATE_EX);
    step(STATE_MEM);

    // Two-cycle WB: request only honoured on the second cycle
    opcode_group = '0;
    opcode_group[GROUP_TWO_CYCLE_WB] = 1'b1;
    apply_stimulus(STATE_WB, 1'b0, 1'b1, 1'b0, 10'h100, 12'h000, 1'b0);
    check_output("wb2_first_ignored", 32'(pc), 32'h004);
    apply_stimulus(STATE_WB, 1'b1, 1'b0, 1'b0, 10'h100, 12'h000, 1'b0);
    check_output("wb2_no_jump", 32'(pc), 32'h004);
    fetch("wb2_fetch", 10'h004, 16'h5555, 1'b0, 10'h005);
    step(STATE_EX);
    step(STATE_MEM);
    apply_stimulus(STATE_WB, 1'b0, 1'b0, 1'b0, 10'h000, 12'h000, 1'b0);
    apply_stimulus(STATE_WB, 1'b1, 1'b1, 1'b0, 10'h100, 12'h000, 1'b0);
    check_output("wb2_second_jump", 32'(pc), 32'h100);
    opcode_group = '0;
    fetch("wb2_target", 10'h100, 16'h6666, 1'b0, 10'h101);

    // Requests outside WB-last and undefined state codes are ignored
    apply_stimulus(STATE_EX, 1'b0, 1'b1, 1'b1, 10'h200, 12'h010, 1'b1);
    check_output("ex_req_ignored", 32'(pc), 32'h101);
    apply_stimulus(core_state_t'(3'd7), 1'b1, 1'b1, 1'b0, 10'h200, 12'h000, 1'b1);
    check_output("undef_pc", 32'(pc), 32'h101);
    check_output("undef_instr", 32'(instr), 32'h6666);
    step(STATE_MEM);
    step(STATE_WB);
    fetch("no_stray_skip", 10'h101, 16'h7777, 1'b0, 10'h102);
    step(STATE_EX);
    step(STATE_MEM);
    apply_stimulus(STATE_WB, 1'b0, 1'b1, 1'b0, 10'h09F, 12'h000, 1'b0);

    // Async reset mid-MEM with a skip pending
    fetch("pre_reset", 10'h09F, 16'h9F9F, 1'b0, 10'h0A0);
    step(STATE_EX);
    step(STATE_MEM);
    apply_stimulus(STATE_WB, 1'b0, 1'b0, 1'b0, 10'h000, 12'h000, 1'b1);
    check_output("pre_reset_pc", 32'(pc), 32'h0A0);
    step(STATE_ID);
    step(STATE_EX);
    @(negedge clk);
    state = STATE_MEM;
    #2;
    reset = 1'b1;
    #1;
    check_output("async_pc", 32'(pc), 32'h0);
    check_output("async_instr", 32'(instr), 32'h0);
    check_output("async_squashed", 32'(instr_squashed), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    state = STATE_RESET;
    @(posedge clk);
    #1;
    fetch("post_reset", 10'h000, 16'h1111, 1'b0, 10'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
